// File: rtl/pat_count_stream.sv
// Streaming pattern-occurrence counter: one symbol per cycle over valid/ready.
// ctb counts matches inside each symbol; cts also counts windows that straddle symbols.
module pat_count_stream #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned SYM_W = 8,
  parameter int unsigned N_SYM = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pat,
  input  logic             in_valid,
  input  logic [SYM_W-1:0] in_sym,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ctb,
  output logic [CNT_W-1:0] cts
);

  localparam int unsigned SUM_W = CNT_W + 2;
  localparam int unsigned IDX_W = (N_SYM > 1) ? $clog2(N_SYM) : 1;
  localparam int unsigned CAT_W = SYM_W + PAT_W - 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((2 ** CNT_W) - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [PAT_W-1:0]   pat_q;
  logic [PAT_W-2:0]   tail;
  logic [IDX_W-1:0]   idx;

  logic [SUM_W-1:0]   inm_c;
  logic [SUM_W-1:0]   crs_c;
  logic [SUM_W-1:0]   ctb_sum_c;
  logic [SUM_W-1:0]   cts_sum_c;
  logic [CAT_W-1:0]   cat_c;
  logic               accept_c;
  logic               last_c;

  function automatic logic [CNT_W-1:0] sat(input logic [SUM_W-1:0] v);
    return (v > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(v);
  endfunction

  // Match counts for the symbol on the bus; only used on an accepting edge.
  always_comb begin
    inm_c     = '0;
    crs_c     = '0;
    cat_c     = {tail, in_sym};
    for (int k = 0; k <= int'(SYM_W - PAT_W); k++) begin
      if (in_sym[k +: PAT_W] == pat_q) inm_c = inm_c + SUM_W'(1);
    end
    // Windows that start in the previous symbol's tail and end in this one.
    for (int k = int'(SYM_W - PAT_W + 1); k <= int'(SYM_W) - 1; k++) begin
      if (cat_c[k +: PAT_W] == pat_q) crs_c = crs_c + SUM_W'(1);
    end
    if (idx == '0) crs_c = '0;
    ctb_sum_c = {2'b00, ctb} + inm_c;
    cts_sum_c = {2'b00, cts} + inm_c + crs_c;
  end

  assign accept_c = (state == S_RUN) && in_ready && in_valid && !start;
  assign last_c   = (idx == IDX_W'(N_SYM - 1));

  // Control FSM with registered handshake, status and count outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ctb      <= '0;
      cts      <= '0;
      pat_q    <= '0;
      tail     <= '0;
      idx      <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state    <= S_RUN;
        pat_q    <= pat;
        ctb      <= '0;
        cts      <= '0;
        idx      <= '0;
        in_ready <= 1'b1;
        busy     <= 1'b1;
      end else begin
        case (state)
          S_RUN: begin
            if (accept_c) begin
              ctb  <= sat(ctb_sum_c);
              cts  <= sat(cts_sum_c);
              tail <= in_sym[PAT_W-2:0];
              idx  <= idx + IDX_W'(1);
              if (last_c) begin
                state    <= S_DONE;
                in_ready <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pat_count_stream.sv
// Scoreboard bench for pat_count_stream: default instance plus a CNT_W=4 instance
// sharing the same stimulus, checked by independent done-triggered monitors.
module tb_pat_count_stream;

  localparam int unsigned N_SYM = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] pat;
  logic       in_valid;
  logic [7:0] in_sym;

  logic       in_ready8, busy8, done8;
  logic [7:0] ctb8, cts8;
  logic       in_ready4, busy4, done4;
  logic [3:0] ctb4, cts4;

  always #5 clk = ~clk;

  pat_count_stream #(.PAT_W(4), .SYM_W(8), .N_SYM(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .pat(pat), .in_valid(in_valid),
    .in_sym(in_sym), .in_ready(in_ready8), .busy(busy8), .done(done8),
    .ctb(ctb8), .cts(cts8)
  );

  pat_count_stream #(.PAT_W(4), .SYM_W(8), .N_SYM(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .pat(pat), .in_valid(in_valid),
    .in_sym(in_sym), .in_ready(in_ready4), .busy(busy4), .done(done4),
    .ctb(ctb4), .cts(cts4)
  );

  typedef struct {
    int ctb;
    int cts;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int hold_ctb8, hold_cts8;
  logic [7:0] sy[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitors: every done pulse pops one expected result per instance.
  always @(posedge clk) begin
    #1;
    if (done8) begin
      if (q8.size() == 0) check("unexpected_done8", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q8.pop_front();
        check("ctb8", ctb8, e.ctb);
        check("cts8", cts8, e.cts);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (done4) begin
      if (q4.size() == 0) check("unexpected_done4", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q4.pop_front();
        check("ctb4", ctb4, e.ctb);
        check("cts4", cts4, e.cts);
      end
    end
  end

  task automatic expect_job(input int b8, input int s8, input int b4, input int s4);
    q8.push_back('{b8, s8});
    q4.push_back('{b4, s4});
    hold_ctb8 = b8;
    hold_cts8 = s8;
  endtask

  task automatic start_job(input logic [3:0] p, input logic with_valid);
    @(negedge clk);
    start    = 1'b1;
    pat      = p;
    in_valid = with_valid;
    in_sym   = 8'hFF;
    cyc      = 1;
  endtask

  task automatic feed(input int n, input bit toggle);
    int  i     = 0;
    int  guard = 0;
    bit  ph    = 1'b1;
    while (i < n && guard < 100) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      guard++;
      if (in_ready8 && (!toggle || ph)) begin
        in_valid = 1'b1;
        in_sym   = sy[i];
        i++;
      end else begin
        in_valid = 1'b0;
        in_sym   = 8'($urandom);
      end
      ph = ~ph;
    end
    if (guard >= 100) check("feed_timeout", 32'(i), 32'(n));
  endtask

  task automatic finish_job(input bit chk_lat);
    int guard = 0;
    do begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      cyc++;
      guard++;
    end while (!done8 && guard < 40);
    check("done_seen", done8, 1);
    if (chk_lat) check("latency_cycles", cyc, N_SYM + 2);
    repeat (3) @(negedge clk);
    check("hold_ctb", ctb8, hold_ctb8);
    check("hold_cts", cts8, hold_cts8);
    check("idle_busy", busy8, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, in_ready8, 0);
    check({tag, "_busy"}, busy8, 0);
    check({tag, "_done"}, done8, 0);
    check({tag, "_ctb"}, ctb8, 0);
    check({tag, "_cts"}, cts8, 0);
    check({tag, "_ctb4"}, ctb4, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    pat      = 4'h0;
    in_valid = 1'b0;
    in_sym   = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Valid in IDLE must be ignored.
    @(negedge clk);
    in_valid = 1'b1;
    in_sym   = 8'h00;
    @(negedge clk);
    check("idle_ready", in_ready8, 0);
    check("idle_ctb", ctb8, 0);
    in_valid = 1'b0;

    // All-zero string, pattern 0, full rate.
    for (int i = 0; i < 8; i++) sy[i] = 8'h00;
    expect_job(40, 61, 15, 15);
    start_job(4'b0000, 1'b0);
    feed(8, 1'b0);
    finish_job(1'b1);

    // Single straddling match only.
    sy[0] = 8'h01;
    sy[1] = 8'h20;
    for (int i = 2; i < 8; i++) sy[i] = 8'h00;
    expect_job(0, 1, 0, 1);
    start_job(4'b1001, 1'b0);
    feed(8, 1'b0);
    finish_job(1'b1);

    // All ones with in_valid toggling.
    for (int i = 0; i < 8; i++) sy[i] = 8'hFF;
    expect_job(40, 61, 15, 15);
    start_job(4'b1111, 1'b0);
    feed(8, 1'b1);
    finish_job(1'b0);

    // Abort after 3 accepts; restart with a same-cycle symbol that must be dropped.
    for (int i = 0; i < 8; i++) sy[i] = 8'hFF;
    start_job(4'b1111, 1'b0);
    feed(3, 1'b0);
    for (int i = 0; i < 8; i++) sy[i] = 8'h0F;
    expect_job(8, 8, 8, 8);
    start_job(4'b1111, 1'b1);
    check("abort_busy", busy8, 1);
    feed(8, 1'b0);
    finish_job(1'b1);

    // Asynchronous reset in the middle of a job.
    for (int i = 0; i < 8; i++) sy[i] = 8'h00;
    start_job(4'b0000, 1'b0);
    feed(4, 1'b0);
    @(posedge clk);
    #3;
    check("pre_reset_ctb_nonzero", (ctb8 != 8'd0), 1);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Clean job after reset.
    expect_job(40, 61, 15, 15);
    start_job(4'b0000, 1'b0);
    feed(8, 1'b0);
    finish_job(1'b1);

    repeat (3) @(negedge clk);
    check("q8_drained", 32'(q8.size()), 0);
    check("q4_drained", 32'(q4.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
